// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame format and received-byte signals of uart_rx.
// The receiver connects through the slave modport; whoever drives the serial
// line and consumes bytes uses the master modport. state_dbg mirrors the
// receiver FSM state for observation.
interface uart_rx_if;
    logic       serial_i;
    logic       two_stop_bits_i;
    logic       parity_bit_i;
    logic       parity_even_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_error_o;
    logic       frame_error_o;
    logic       busy_o;
    logic [2:0] state_dbg;

    modport master (
        output serial_i, two_stop_bits_i, parity_bit_i, parity_even_i,
        input  data_o, valid_o, parity_error_o, frame_error_o, busy_o, state_dbg
    );

    modport slave (
        input  serial_i, two_stop_bits_i, parity_bit_i, parity_even_i,
        output data_o, valid_o, parity_error_o, frame_error_o, busy_o, state_dbg
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Each received byte is presented with a one-cycle valid_o
// pulse together with parity and framing status.
// Handshake: valid_o is a pulse with no back-pressure; data_o and the error
// flags change only in the cycle valid_o is high and hold until the next one.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit,
// adds one clock of latency).
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 435
) (
    input  logic    clock_i,
    input  logic    reset_ni,
    uart_rx_if.slave rx
);
    localparam int CW  = $clog2(CLOCKS_PER_BIT);
    localparam int MID = CLOCKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    // Sample one clock after mid-bit so the vote window is mid-1..mid+1.
    localparam logic [CW-1:0] START_PT = CW'(MID + 1);
`else
    localparam logic [CW-1:0] START_PT = CW'(MID);
`endif
    // After START the counter is realigned, so one full bit period later
    // lands on the same point of the next bit.
    localparam logic [CW-1:0] BIT_PT = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          perr, perr_n, ferr, ferr_n;
    logic          cfg_two, cfg_two_n, cfg_par, cfg_par_n, cfg_even, cfg_even_n;
    logic          finish;

    logic          s_meta, s_sync, s_prev;
    logic          bit_val, fall;

    logic [7:0]    data_r;
    logic          valid_r, perr_r, ferr_r;

`ifdef UART_RX_MAJORITY_EN
    logic          s_prev2;

    // Synchroniser plus two cycles of history for the majority vote.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s_meta  <= 1'b1;
            s_sync  <= 1'b1;
            s_prev  <= 1'b1;
            s_prev2 <= 1'b1;
        end else begin
            s_meta  <= rx.serial_i;
            s_sync  <= s_meta;
            s_prev  <= s_sync;
            s_prev2 <= s_prev;
        end
    end

    assign bit_val = (s_sync & s_prev) | (s_sync & s_prev2) | (s_prev & s_prev2);
`else
    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s_meta <= 1'b1;
            s_sync <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s_meta <= rx.serial_i;
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end

    assign bit_val = s_sync;
`endif

    assign fall = s_prev & ~s_sync;

    // FSM and frame datapath registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            cfg_two  <= 1'b0;
            cfg_par  <= 1'b0;
            cfg_even <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
            cfg_two  <= cfg_two_n;
            cfg_par  <= cfg_par_n;
            cfg_even <= cfg_even_n;
        end
    end

    // Next-state and datapath updates; sampling happens only on bit ticks.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        perr_n     = perr;
        ferr_n     = ferr;
        cfg_two_n  = cfg_two;
        cfg_par_n  = cfg_par;
        cfg_even_n = cfg_even;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    state_n    = START;
                    bit_idx_n  = '0;
                    perr_n     = 1'b0;
                    ferr_n     = 1'b0;
                    cfg_two_n  = rx.two_stop_bits_i;
                    cfg_par_n  = rx.parity_bit_i;
                    cfg_even_n = rx.parity_even_i;
                end
            end
            START: begin
                if (cnt == START_PT) begin
                    cnt_n   = '0;
                    state_n = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_PT) begin
                    cnt_n     = '0;
                    shift_n   = {bit_val, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = cfg_par ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (cnt == BIT_PT) begin
                    cnt_n   = '0;
                    perr_n  = (^shift) ^ bit_val ^ ~cfg_even;
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (cnt == BIT_PT) begin
                    cnt_n = '0;
                    if (!bit_val) ferr_n = 1'b1;
                    if (cfg_two) begin
                        state_n = STOP2;
                    end else begin
                        state_n = IDLE;
                        finish  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (cnt == BIT_PT) begin
                    cnt_n   = '0;
                    if (!bit_val) ferr_n = 1'b1;
                    state_n = IDLE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output registers: byte and status update together with the valid pulse.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            valid_r <= finish;
            if (finish) begin
                data_r <= shift_n;
                perr_r <= perr_n;
                ferr_r <= ferr_n;
            end
        end
    end

    assign rx.data_o         = data_r;
    assign rx.valid_o        = valid_r;
    assign rx.parity_error_o = perr_r;
    assign rx.frame_error_o  = ferr_r;
    assign rx.busy_o         = (state != IDLE);
    assign rx.state_dbg      = state;

endmodule
